// File: rtl/rf_wb_pkg.sv
// Shared defaults and types for the register-file writeback queue.
package rf_wb_pkg;

    localparam int DEPTH_DEF = 4;
    localparam int AW_DEF    = 4;
    localparam int DW_DEF    = 16;

    // Writes to register 0 are architecturally discarded.
    localparam int R0_ADDR   = 0;

    typedef struct packed {
        logic [AW_DEF-1:0] addr;
        logic [DW_DEF-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// In-order circular buffer: up to two pushes and one pop per clock.
// Entry contents and a per-slot valid vector are exposed so the top
// level can search pending writes for forwarding.
module rf_wb_fifo
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push0_i,
    input  logic [AW-1:0]                push0_addr_i,
    input  logic [DW-1:0]                push0_data_i,
    input  logic                         push1_i,
    input  logic [AW-1:0]                push1_addr_i,
    input  logic [DW-1:0]                push1_data_i,
    input  logic                         pop_i,
    output logic [AW-1:0]                head_addr_o,
    output logic [DW-1:0]                head_data_o,
    output logic [$clog2(DEPTH):0]       cnt_o,
    output logic [$clog2(DEPTH)-1:0]     rd_ptr_o,
    output logic [DEPTH-1:0]             ent_vld_o,
    output logic [DEPTH-1:0][AW-1:0]     ent_addr_o,
    output logic [DEPTH-1:0][DW-1:0]     ent_data_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0][AW-1:0] addr_q;
    logic [DEPTH-1:0][DW-1:0] data_q;
    logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [PW-1:0]            push1_slot;

    // Next pointers/occupancy; the second push lands after the first when both fire.
    always_comb begin
        wr_ptr_d   = wr_ptr_q + PW'(push0_i) + PW'(push1_i);
        rd_ptr_d   = rd_ptr_q + PW'(pop_i);
        cnt_d      = cnt_q + CW'(push0_i) + CW'(push1_i) - CW'(pop_i);
        push1_slot = push0_i ? wr_ptr_q + PW'(1) : wr_ptr_q;
    end

    // Pointer and occupancy registers; reset discards all entries.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Entry storage; contents are qualified by occupancy so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (push0_i) begin
            addr_q[wr_ptr_q] <= push0_addr_i;
            data_q[wr_ptr_q] <= push0_data_i;
        end
        if (push1_i) begin
            addr_q[push1_slot] <= push1_addr_i;
            data_q[push1_slot] <= push1_data_i;
        end
    end

    // A slot is live when its distance from the head is below the occupancy.
    always_comb begin
        ent_vld_o = '0;
        for (int k = 0; k < DEPTH; k++) begin
            ent_vld_o[k] = {1'b0, PW'(k) - rd_ptr_q} < cnt_q;
        end
    end

    assign head_addr_o = addr_q[rd_ptr_q];
    assign head_data_o = data_q[rd_ptr_q];
    assign cnt_o       = cnt_q;
    assign rd_ptr_o    = rd_ptr_q;
    assign ent_addr_o  = addr_q;
    assign ent_data_o  = data_q;

endmodule

// File: rtl/rf_wb_queue.sv
// Writeback queue feeding the register-file write port from the ALU and
// load unit, with pending-write forwarding and a hazard busy flag.
module rf_wb_queue
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   alu_vld_i,
    input  logic [AW-1:0]          alu_addr_i,
    input  logic [DW-1:0]          alu_data_i,
    output logic                   alu_rdy_o,
    input  logic                   ld_vld_i,
    input  logic [AW-1:0]          ld_addr_i,
    input  logic [DW-1:0]          ld_data_i,
    output logic                   ld_rdy_o,
    output logic                   rf_we_o,
    output logic [AW-1:0]          rf_dst_addr_o,
    output logic [DW-1:0]          rf_dst_o,
    input  logic [AW-1:0]          fwd_addr_i,
    output logic                   fwd_hit_o,
    output logic [DW-1:0]          fwd_data_o,
    output logic                   busy_o,
    output logic [$clog2(DEPTH):0] pend_cnt_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic                     alu_push, ld_push, pop;
    logic [AW-1:0]            head_addr;
    logic [DW-1:0]            head_data;
    logic [CW-1:0]            cnt;
    logic [PW-1:0]            rd_ptr;
    logic [DEPTH-1:0]         ent_vld;
    logic [DEPTH-1:0][AW-1:0] ent_addr;
    logic [DEPTH-1:0][DW-1:0] ent_data;
    logic                     rf_we_q;
    logic [AW-1:0]            rf_dst_addr_q;
    logic [DW-1:0]            rf_dst_q;

    // Readiness looks only at registered occupancy; a load needs two free
    // slots so a simultaneous ALU push can never overflow the queue.
    assign alu_rdy_o = !rst_i && (cnt < CW'(DEPTH));
    assign ld_rdy_o  = !rst_i && (cnt < CW'(DEPTH - 1));

    // Transfers to register 0 are accepted but never enqueued.
    assign alu_push = alu_vld_i && alu_rdy_o && (alu_addr_i != AW'(R0_ADDR));
    assign ld_push  = ld_vld_i  && ld_rdy_o  && (ld_addr_i  != AW'(R0_ADDR));
    assign pop      = (cnt != '0);

    rf_wb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push0_i      (alu_push),
        .push0_addr_i (alu_addr_i),
        .push0_data_i (alu_data_i),
        .push1_i      (ld_push),
        .push1_addr_i (ld_addr_i),
        .push1_data_i (ld_data_i),
        .pop_i        (pop),
        .head_addr_o  (head_addr),
        .head_data_o  (head_data),
        .cnt_o        (cnt),
        .rd_ptr_o     (rd_ptr),
        .ent_vld_o    (ent_vld),
        .ent_addr_o   (ent_addr),
        .ent_data_o   (ent_data)
    );

    // Output register: one write per clock from the head; addr/data hold when idle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rf_we_q       <= 1'b0;
            rf_dst_addr_q <= '0;
            rf_dst_q      <= '0;
        end else if (pop) begin
            rf_we_q       <= 1'b1;
            rf_dst_addr_q <= head_addr;
            rf_dst_q      <= head_data;
        end else begin
            rf_we_q       <= 1'b0;
        end
    end

    // Forwarding: output register lowest priority, then queue oldest to
    // youngest so the youngest matching entry overrides.
    always_comb begin
        fwd_hit_o  = 1'b0;
        fwd_data_o = '0;
        if (fwd_addr_i != AW'(R0_ADDR)) begin
            if (rf_we_q && (rf_dst_addr_q == fwd_addr_i)) begin
                fwd_hit_o  = 1'b1;
                fwd_data_o = rf_dst_q;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_vld[rd_ptr + PW'(i)] && (ent_addr[rd_ptr + PW'(i)] == fwd_addr_i)) begin
                    fwd_hit_o  = 1'b1;
                    fwd_data_o = ent_data[rd_ptr + PW'(i)];
                end
            end
        end
    end

    assign rf_we_o       = rf_we_q;
    assign rf_dst_addr_o = rf_dst_addr_q;
    assign rf_dst_o      = rf_dst_q;
    assign busy_o        = pop || rf_we_q;
    assign pend_cnt_o    = cnt;

endmodule

// File: doc/rf_wb_queue.md
# rf_wb_queue

Writeback queue that drives the register file's write port (`we`, `dst_addr`, `dst`). It accepts results from two producers, the ALU and the load unit, and buffers them in a small in-order FIFO. It issues at most one register write per clock. It also provides a forwarding lookup so that decode can read values that are still pending, and a busy flag for hazard stalls.

## Interface
- `DEPTH`, 4, number of queue entries (power of 2, ≥2)
- `AW`, 4, register address width
- `DW`, 16, register data width

- `clk`  in  1  clock; all state updates on posedge
- `rst`  in  1  synchronous, active-high reset
- `alu_vld`  in  1  ALU result valid
- `alu_addr`  in  AW  ALU destination register
- `alu_data`  in  DW  ALU result
- `alu_rdy`  out  1  queue can accept an ALU result this cycle
- `ld_vld`  in  1  load result valid
- `ld_addr`  in  AW  load destination register
- `ld_data`  in  DW  load data
- `ld_rdy`  out  1  queue can accept a load result this cycle
- `rf_we`  out  1  register-file write enable (registered)
- `rf_dst_addr`  out  AW  register-file write address (registered)
- `rf_dst`  out  DW  register-file write data (registered)
- `fwd_addr`  in  AW  forwarding lookup address
- `fwd_hit`  out  1  a pending write to `fwd_addr` exists
- `fwd_data`  out  DW  newest pending data for `fwd_addr`
- `busy`  out  1  queue non-empty or `rf_we` high
- `pend_cnt`  out  $clog2(DEPTH)+1  current queue occupancy

## Operation
- **Ready signals.** Both depend only on registered occupancy, never on `*_vld`.
  - `alu_rdy = !rst && (DEPTH - cnt) >= 1`
  - `ld_rdy = !rst && (DEPTH - cnt) >= 2`
- **Transfer.** A transfer occurs when `vld && rdy`. `*_vld` with `rdy` low is ignored; the producer holds.
- **R0 filter.** A transfer with addr == 0 is accepted and dropped. It is not enqueued and does not count toward occupancy.
- **Push order.** When both producers transfer in the same cycle, the ALU entry is enqueued first (older) and the load entry second (younger). Up to 2 pushes per cycle.
- **Pop.** Each posedge with `cnt > 0`, the head is popped into `rf_we/rf_dst_addr/rf_dst` with `rf_we = 1`. With `cnt == 0`, `rf_we = 0`; addr and data hold their last values.
- **Simultaneous push and pop.** Both occur in the same cycle. The next `cnt` is `cnt + pushes - pop`. A push into an empty queue is not popped in the same edge.
- **Forwarding (combinational).** Search all valid queue entries plus the output register (when `rf_we = 1`) for a match on `fwd_addr`.
  - Priority: youngest queue entry first, then the output register last.
  - No match or `fwd_addr == 0`: `fwd_hit = 0`, `fwd_data = 0`.
- **Ordering.** Writes reach the register file in acceptance order. Same-address writes are never merged or reordered.

## Timing
- **Reset.** `cnt = 0`, pointers = 0, `rf_we = 0`, `rf_dst_addr = 0`, `rf_dst = 0`. All queued entries are discarded.
  - During reset, `alu_rdy` and `ld_rdy` are 0.
  - Reset asserted mid-drain kills any pending write: `rf_we = 0` on the next edge.
- **Latency.** A result accepted at edge N into an empty queue appears with `rf_we = 1` after edge N+1, and is visible for one cycle.
- **Throughput.** One write per cycle. A sustained dual push fills the queue; `ld_rdy` drops first (free < 2), then `alu_rdy` drops (full).
- **Wrap-around.** Pointers wrap modulo DEPTH. A dual push that straddles the wrap point writes entries DEPTH-1 and 0.
- **Full/empty.** `cnt == DEPTH` means full; `cnt == 0` means empty. No overflow is possible because of the ready rules.
- **Forward timing.** `fwd_hit/fwd_data` reflect state after the last posedge. Same-cycle incoming producer data is not forwarded.

## Structure
- **Package `rf_wb_pkg`:** `DW`, `AW`, `DEPTH` defaults; `wb_entry_t` struct {addr[AW], data[DW]}; constant `R0_ADDR = 0`.
- **Sub-module `rf_wb_fifo`:** circular buffer with two-push/one-pop, pointers, `cnt`, and an entry-valid vector exposed for the forwarding search.
- **Top level:** ready generation, R0 filter, output register, forwarding priority mux.

## Test plan
- **Single write.** Reset, then ALU push (addr 3, 0xBEEF) → one cycle later `rf_we = 1`, `rf_dst_addr = 3`, `rf_dst = 0xBEEF`. `pend_cnt` goes 1 then 0.
- **Dual push order.** ALU (5, 0x1111) and load (5, 0x2222) pushed together → writes occur in the order 0x1111 then 0x2222. `fwd_addr = 5` returns 0x2222 while both are pending, and 0x2222 after the first write.
- **R0 drop.** ALU push to addr 0 with data 0xFFFF → `alu_rdy = 1`, `pend_cnt` stays 0, `rf_we` never asserts, `fwd_hit = 0` for addr 0.
- **Backpressure/wrap.** Dual pushes every cycle for 8 cycles, DEPTH = 4 → `ld_rdy = 0` once `cnt ≥ 3`, `alu_rdy = 0` at `cnt = 4`. All accepted writes emerge in order across the pointer wrap, with none lost or duplicated.
- **Mid-drain reset.** Queue holding 3 entries, `rst` asserted for 1 cycle → `rf_we = 0`, `pend_cnt = 0`, and no further writes. After reset, `alu_rdy = 1`.
- **Forward miss.** Queue holds writes to registers 2 and 7; `fwd_addr = 4` → `fwd_hit = 0`, `fwd_data = 0`.
